// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes, FSM states and the default operand width.
package alu_muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FIX    = 2'b10,
        FINISH = 2'b11
    } state_e;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negate; purely combinational, zero latency.
// Used for operand magnitudes and for the sign fix-up of results.
module cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative one-bit-per-clock multiply (shift-add) / divide (restoring) unit.
// DONE pulses WIDTH+2 edges after the START edge; START is only honoured in IDLE.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DIV_BY_ZERO
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e               state;
    state_e               state_nxt;
    logic [CW-1:0]        cnt;
    logic                 div_q;
    logic                 sign_res;
    logic                 sign_rem;
    logic                 dbz_q;
    logic [WIDTH-1:0]     a_raw;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;

    logic                 accept;
    logic                 last_iter;
    logic                 in_div;
    logic                 in_signed;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   fix_prod;
    logic [WIDTH-1:0]     fix_quo;
    logic [WIDTH-1:0]     fix_rem;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   mul_step;
    logic [2*WIDTH-1:0]   div_step;

    assign in_div    = (OP == OP_DIVU) || (OP == OP_DIV);
    assign in_signed = (OP == OP_MUL)  || (OP == OP_DIV);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // 0x80..0 negates to itself, which read as unsigned is the correct magnitude.
    cond_negate #(.W(WIDTH)) u_neg_a (.din(A), .neg(in_signed & A[WIDTH-1]), .dout(mag_a));
    cond_negate #(.W(WIDTH)) u_neg_b (.din(B), .neg(in_signed & B[WIDTH-1]), .dout(mag_b));

    cond_negate #(.W(2*WIDTH)) u_fix_prod (.din(acc), .neg(sign_res), .dout(fix_prod));
    cond_negate #(.W(WIDTH)) u_fix_quo (.din(acc[WIDTH-1:0]), .neg(sign_res), .dout(fix_quo));
    cond_negate #(.W(WIDTH)) u_fix_rem (.din(acc[2*WIDTH-1:WIDTH]), .neg(sign_rem), .dout(fix_rem));

    // Multiply: acc = {partial, multiplier}; add on LSB, shift right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START)     state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:                    state_nxt = FINISH;
            FINISH:                 state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state == CALC) || (state == FIX);
        accept = (state == IDLE) && START;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            div_q       <= 1'b0;
            sign_res    <= 1'b0;
            sign_rem    <= 1'b0;
            dbz_q       <= 1'b0;
            a_raw       <= '0;
            opnd        <= '0;
            acc         <= '0;
            DONE        <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (accept) begin
                div_q    <= in_div;
                sign_res <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                sign_rem <= in_signed & A[WIDTH-1];
                dbz_q    <= in_div && (B == '0);
                a_raw    <= A;
                opnd     <= in_div ? mag_b : mag_a;
                acc      <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                cnt      <= '0;
            end
            case (state)
                CALC: begin
                    acc <= div_q ? div_step : mul_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: acc <= div_q ? {fix_rem, fix_quo} : fix_prod;
                FINISH: begin
                    DONE        <= 1'b1;
                    HI          <= dbz_q ? a_raw : acc[2*WIDTH-1:WIDTH];
                    LO          <= dbz_q ? {WIDTH{1'b1}} : acc[WIDTH-1:0];
                    DIV_BY_ZERO <= dbz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative multi-cycle multiply/divide unit for the CS147 processor ALU.
- Computes a 2·WIDTH-bit product, or a quotient and remainder, one bit per clock.
- Its registered HI/LO outputs feed the multiply/divide data inputs of the ALU's 32-bit 16-to-1 result-select mux.
- A start/busy/done handshake lets the control unit stall while an operation completes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request a new operation; sampled only in IDLE.
- OP  in  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- A  in  WIDTH  multiplicand / dividend.
- B  in  WIDTH  multiplier / divisor.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse; HI/LO/DIV_BY_ZERO valid in that cycle.
- HI  out  WIDTH  product upper half, or remainder.
- LO  out  WIDTH  product lower half, or quotient.
- DIV_BY_ZERO  out  1  set with DONE when a divide had B==0; held with results.

Behaviour:
Reset:
- While RST=1: state=IDLE; BUSY=0, DONE=0, HI=0, LO=0, DIV_BY_ZERO=0; counter=0.
- Reset asserted mid-operation aborts it. No DONE is produced and outputs are zeroed.

States: IDLE -> CALC -> FIX -> FINISH -> IDLE.
- IDLE: on an edge with START=1, latch OP, A and B.
  - For signed ops, convert the operands to magnitudes and record the result sign and remainder sign (remainder sign = dividend sign).
  - Clear the accumulator and counter; go to CALC.
- CALC: exactly WIDTH cycles, one iteration per cycle.
  - Multiply: shift-add on a 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract on remainder/quotient.
  - Counter width is $clog2(WIDTH+1). Leave CALC when counter reaches WIDTH-1.
- FIX: one cycle.
  - Multiply: conditionally two's-complement negate the 2·WIDTH result.
  - Divide: negate the quotient if operand signs differ; negate the remainder if the dividend was negative.
- FINISH: load HI/LO, DONE=1 for this single cycle, return to IDLE.

Timing and hold:
- Latency: DONE is high during the cycle after the (WIDTH+2)th rising edge following the edge that sampled START (34 edges at default).
- BUSY=1 in CALC and FIX, and 0 in FINISH and IDLE.
- HI/LO/DIV_BY_ZERO hold their values until the next accepted START. On that START they are held (not cleared) until the next FINISH.

Edge cases:
- START while BUSY or in FINISH is ignored; the operands and OP of the in-flight operation are unaffected.
- START in the same cycle as FINISH is ignored; START is accepted only from IDLE.
- Divide by zero takes the same latency. Result: LO = all ones, HI = A (raw input, not the magnitude), DIV_BY_ZERO=1.
- Signed overflow, MIN/-1: LO = MIN (0x80000000), HI = 0, no flag.
- Most-negative operand magnitude: 0x80000000 is treated as unsigned 2^31, so the magnitude path needs no extra bit.
- Multiply never sets DIV_BY_ZERO; it is cleared in FINISH for multiply ops.

Decomposition:
Shared package (alu_muldiv_pkg):
- OP encodings: OP_MULU, OP_MUL, OP_DIVU, OP_DIV.
- State encoding: IDLE, CALC, FIX, FINISH.
- Default WIDTH constant.

One natural sub-module: cond_negate, a parameterized-width conditional two's-complement negate. It is reused for operand magnitude conversion and for FIX.

Test Plan:
1. MULU, A=0xFFFFFFFF, B=0xFFFFFFFF, START 1 cycle -> BUSY next cycle; DONE exactly 34 edges later; HI=0xFFFFFFFE, LO=0x00000001; DIV_BY_ZERO=0.
2. MUL, A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). Then MUL with A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
3. DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU, A=100, B=7 -> LO=14, HI=2.
4. DIVU, A=100, B=0 -> DONE at 34 edges; LO=0xFFFFFFFF, HI=100, DIV_BY_ZERO=1. A following MULU 2×3 -> HI=0, LO=6, DIV_BY_ZERO=0.
5. DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DIV_BY_ZERO=0. Pulse START with MULU 5×5 at cycle 10 of that op -> ignored; only one DONE, with the DIV results.
6. MULU 9×9 started; assert RST asynchronously mid-cycle at CALC cycle 12 -> BUSY, DONE, HI and LO go 0 immediately with no DONE afterwards. After release, MULU 9×9 -> LO=81, HI=0 after 34 edges.
